multipath_spy_seq_trigger: RTL and testbench
============================================

// Module: multipath_spy_seq_trigger
// PURPOSE
// - Parametrised multi-channel delay-path spy block: CHANNELS inverter-chain paths (STAGES keep-attributed nand(x,Vcc) stages each) with an embedded trojan payload.
// - Payload XORs onto masked path inputs once a sequential trigger arms; an on-chip launch/capture FSM exercises every path and counts corrupted captures.
// - Sits between the spy trigger inputs and the delay-measurement fabric.
// PARAMETERS
// CHANNELS        4   number of independent delay paths
// STAGES          16  inverting stages per path; must be even (path is non-inverting)
// TRIG_THRESHOLD  8   sampled ht_in1&ht_in2 cycles (cumulative) needed to arm payload, >=1
// CAPTURE_WAIT    2   cycles between launch and capture, >=1
// CNT_W           16  width of error counter
// PORTS
// clk       in   1         clock
// rst       in   1         synchronous reset, active-high
// Vcc       in   1         logic-1 tie used by chain gates (bench drives 1)
// gnd       in   1         logic-0 tie used by chain gates (bench drives 0)
// ht_in1    in   1         trojan trigger input 1
// ht_in2    in   1         trojan trigger input 2
// ht_mask   in   CHANNELS  channels corrupted by payload
// start     in   1         request one launch/capture run (sampled in IDLE only)
// busy      out  1         FSM not in IDLE
// done      out  1         one-cycle pulse, run complete
// armed     out  1         payload active
// path_out  out  CHANNELS  combinational chain outputs
// mismatch  out  CHANNELS  per-channel mismatch of last capture
// err_cnt   out  CNT_W     runs with any mismatch, saturating
// BEHAVIOUR
// - Reset: single clock; reset is synchronous and active-high. FSM=IDLE, lv=0, trig_cnt=0, armed=0, busy=0, done=0, mismatch=0, err_cnt=0; path_out settles to 0.
// - rst dominates every other event; rst mid-run returns to IDLE next edge, no capture, err_cnt cleared.
// - Path input per channel c: pin[c] = lv ^ (armed & ht_mask[c]); path_out[c] = chain(pin[c]); chain is combinational, no registers inside.
// - Trigger: each edge with ht_in1&ht_in2=1 increments trig_cnt, saturating at TRIG_THRESHOLD; armed is a register set on the edge where trig_cnt reaches TRIG_THRESHOLD, sticky until rst.
// - FSM: IDLE -(start)-> LAUNCH -> WAIT -> CAPTURE -> DONE -> IDLE.
//   LAUNCH: lv <= ~lv, wait_cnt <= 0.  WAIT: stay CAPTURE_WAIT cycles (exit when wait_cnt==CAPTURE_WAIT-1).
//   CAPTURE: mismatch <= path_out ^ {CHANNELS{lv}}; if mismatch nonzero, err_cnt += 1 unless all-ones.
//   DONE: done=1 for that cycle only.
// - Latency: start sampled at edge E -> done high in the cycle after edge E+CAPTURE_WAIT+3.
// - busy=1 in LAUNCH/WAIT/CAPTURE/DONE; start while busy is ignored (not queued).
// - Trigger counting continues during runs; arming mid-WAIT affects that run's capture.
// CONFIGURATION
// - Macro HT_SEQ_TRIGGER_EN:
//   defined: sequential cumulative-count trigger as above.
//   undefined: trig_cnt removed; armed = ht_in1 & ht_in2 combinationally (live, not sticky, no reset dependence).
// TESTING
// 1. rst 2 cycles, Vcc=1 gnd=0 -> busy=0, done=0, armed=0, mismatch=0, err_cnt=0, path_out=4'b0000.
// 2. start 1 cycle, no trigger, CAPTURE_WAIT=2 -> done 5 cycles after sampling edge, path_out=4'b1111, mismatch=0, err_cnt=0.
// 3. ht_in1=ht_in2=1 for 7 cycles -> armed=0; 8th cycle -> armed=1 next cycle; ht_mask=4'b0101, start -> mismatch=4'b0101, err_cnt=1.
// 4. start held high through a run -> exactly one run; next run after done toggles lv, path_out=4'b0000 when unarmed.
// 5. CNT_W=2, armed, ht_mask=4'b0001, 5 runs -> err_cnt 1,2,3,3,3 (saturates).
// 6. rst asserted in WAIT -> IDLE next edge, busy=0, no done pulse, err_cnt=0, armed=0.

Source files
------------

// File: rtl/multipath_spy_seq_trigger_if.sv
// Bus bundle for multipath_spy_seq_trigger: trigger/mask/start controls and observation outputs.
// Master drives stimulus, slave is the spy block.
interface multipath_spy_seq_trigger_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 16
);
  logic                ht_in1;
  logic                ht_in2;
  logic [CHANNELS-1:0] ht_mask;
  logic                start;
  logic                busy;
  logic                done;
  logic                armed;
  logic [CHANNELS-1:0] path_out;
  logic [CHANNELS-1:0] mismatch;
  logic [CNT_W-1:0]    err_cnt;

  modport master (
    output ht_in1, ht_in2, ht_mask, start,
    input  busy, done, armed, path_out, mismatch, err_cnt
  );

  modport slave (
    input  ht_in1, ht_in2, ht_mask, start,
    output busy, done, armed, path_out, mismatch, err_cnt
  );
endinterface

// File: rtl/multipath_spy_seq_trigger.sv
// Multi-channel inverter-chain delay spy with trojan payload and launch/capture self-test FSM.
// Optional macro HT_SEQ_TRIGGER_EN selects the sticky cumulative-count trigger (else live AND trigger).
module multipath_spy_seq_trigger #(
  parameter int unsigned CHANNELS       = 4,
  parameter int unsigned STAGES         = 16,
  parameter int unsigned TRIG_THRESHOLD = 8,
  parameter int unsigned CAPTURE_WAIT   = 2,
  parameter int unsigned CNT_W          = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic Vcc,
  input  logic gnd,
  multipath_spy_seq_trigger_if.slave bus
);

  localparam int unsigned WAIT_W = (CAPTURE_WAIT > 1) ? $clog2(CAPTURE_WAIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_CAPTURE, S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic                lv, lv_nxt;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nxt;
  logic [CHANNELS-1:0] mismatch_q, mismatch_nxt;
  logic [CNT_W-1:0]    err_q, err_nxt;
  logic                done_q, busy_q;
  logic                armed;
  logic [CHANNELS-1:0] pin;
  logic [CHANNELS-1:0] path_out;

  // Trojan trigger
`ifdef HT_SEQ_TRIGGER_EN
  localparam int unsigned TRIG_W = $clog2(TRIG_THRESHOLD + 1);
  logic [TRIG_W-1:0] trig_cnt;
  logic              armed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      trig_cnt <= '0;
      armed_q  <= 1'b0;
    end else if (bus.ht_in1 && bus.ht_in2 && trig_cnt != TRIG_W'(TRIG_THRESHOLD)) begin
      trig_cnt <= TRIG_W'(trig_cnt + 1'b1);
      if (trig_cnt == TRIG_W'(TRIG_THRESHOLD - 1)) armed_q <= 1'b1;
    end
  end

  assign armed = armed_q;
`else
  assign armed = bus.ht_in1 & bus.ht_in2;
`endif

  assign pin = {CHANNELS{lv}} ^ ({CHANNELS{armed}} & bus.ht_mask);

  // Purely combinational nand(x,Vcc) chains; nodes kept so synthesis does not collapse them
  (* keep *) logic node [CHANNELS][STAGES+1];

  always_comb begin
    for (int c = 0; c < int'(CHANNELS); c++) begin
      node[c][0] = pin[c] ^ gnd;
      for (int s = 0; s < int'(STAGES); s++) begin
        node[c][s+1] = ~(node[c][s] & Vcc);
      end
      path_out[c] = node[c][STAGES];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      lv         <= 1'b0;
      wait_cnt   <= '0;
      mismatch_q <= '0;
      err_q      <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      lv         <= lv_nxt;
      wait_cnt   <= wait_cnt_nxt;
      mismatch_q <= mismatch_nxt;
      err_q      <= err_nxt;
      done_q     <= (state == S_DONE);
      busy_q     <= (state_nxt != S_IDLE);
    end
  end

  always_comb begin
    state_nxt    = state;
    lv_nxt       = lv;
    wait_cnt_nxt = wait_cnt;
    mismatch_nxt = mismatch_q;
    err_nxt      = err_q;
    case (state)
      S_IDLE: begin
        if (bus.start) state_nxt = S_LAUNCH;
      end
      S_LAUNCH: begin
        lv_nxt       = ~lv;
        wait_cnt_nxt = '0;
        state_nxt    = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt == WAIT_W'(CAPTURE_WAIT - 1)) state_nxt = S_CAPTURE;
        else wait_cnt_nxt = WAIT_W'(wait_cnt + 1'b1);
      end
      S_CAPTURE: begin
        mismatch_nxt = path_out ^ {CHANNELS{lv}};
        if (|mismatch_nxt && !(&err_q)) err_nxt = err_q + CNT_W'(1);
        state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.armed    = armed;
  assign bus.path_out = path_out;
  assign bus.mismatch = mismatch_q;
  assign bus.err_cnt  = err_q;

endmodule

// File: tb/tb_multipath_spy_seq_trigger.sv
// Randomized bench for multipath_spy_seq_trigger against a run-timeline reference model.
module tb_multipath_spy_seq_trigger;

  localparam int unsigned CH      = 4;
  localparam int unsigned ST      = 16;
  localparam int unsigned TH      = 8;
  localparam int unsigned CW      = 2;
  localparam int unsigned CNT_W   = 2;
  localparam int          ERR_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst, Vcc, gnd;

  always #5 clk = ~clk;

  multipath_spy_seq_trigger_if #(.CHANNELS(CH), .CNT_W(CNT_W)) bus ();

  multipath_spy_seq_trigger #(
    .CHANNELS(CH), .STAGES(ST), .TRIG_THRESHOLD(TH), .CAPTURE_WAIT(CW), .CNT_W(CNT_W)
  ) u_dut (
    .clk(clk), .rst(rst), .Vcc(Vcc), .gnd(gnd), .bus(bus.slave)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: edges elapsed since start was accepted (-1 = no run)
  int          m_phase = -1;
  bit          m_lv    = 1'b0;
  int          m_trig  = 0;
  bit          m_armed = 1'b0;
  int          m_err   = 0;
  bit [CH-1:0] m_mis   = '0;
  bit          m_done  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit armed_exp();
`ifdef HT_SEQ_TRIGGER_EN
    return m_armed;
`else
    return bus.ht_in1 & bus.ht_in2;
`endif
  endfunction

  task automatic model_edge(input bit r, input bit both, input bit [CH-1:0] mask, input bit s);
    bit a;
    if (r) begin
      m_phase = -1; m_lv = 1'b0; m_trig = 0; m_armed = 1'b0;
      m_err = 0; m_mis = '0; m_done = 1'b0;
    end else begin
      a      = armed_exp();
      m_done = (m_phase == int'(CW) + 2);
      if (m_phase == int'(CW) + 1) begin
        m_mis = a ? mask : '0;
        if (m_mis != 0 && m_err < ERR_MAX) m_err++;
      end
      if (m_phase == 0) m_lv = ~m_lv;
      if (m_phase == -1)                 m_phase = s ? 0 : -1;
      else if (m_phase == int'(CW) + 2)  m_phase = -1;
      else                               m_phase++;
      if (both && m_trig < int'(TH)) begin
        m_trig++;
        if (m_trig == int'(TH)) m_armed = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    bit [CH-1:0] pexp;
    pexp = {CH{m_lv}} ^ ({CH{armed_exp()}} & bus.ht_mask);
    check("busy",     32'(bus.busy),     32'(m_phase != -1));
    check("done",     32'(bus.done),     32'(m_done));
    check("armed",    32'(bus.armed),    32'(armed_exp()));
    check("path_out", 32'(bus.path_out), 32'(pexp));
    check("mismatch", 32'(bus.mismatch), 32'(m_mis));
    check("err_cnt",  32'(bus.err_cnt),  32'(m_err));
  endtask

  task automatic step(input bit r, input bit i1, input bit i2, input bit [CH-1:0] mask, input bit s);
    rst = r; bus.ht_in1 = i1; bus.ht_in2 = i2; bus.ht_mask = mask; bus.start = s;
    @(posedge clk);
    model_edge(r, i1 & i2, mask, s);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    Vcc = 1'b1; gnd = 1'b0;
    rst = 1'b1; bus.ht_in1 = 1'b0; bus.ht_in2 = 1'b0; bus.ht_mask = '0; bus.start = 1'b0;

    // Reset state
    step(1, 0, 0, '0, 0);
    step(1, 0, 0, '0, 0);
    check("rst_path", 32'(bus.path_out), 32'h0);
    check("rst_err",  32'(bus.err_cnt),  32'h0);

    // Clean run: done exactly CW+3 edges after the sampling edge
    step(0, 0, 0, '0, 1);
    for (int i = 0; i < int'(CW) + 2; i++) begin
      step(0, 0, 0, '0, 0);
      check("done_early", 32'(bus.done), 32'h0);
    end
    step(0, 0, 0, '0, 0);
    check("done_pulse", 32'(bus.done), 32'h1);
    check("clean_path", 32'(bus.path_out), 32'hf);
    check("clean_mis",  32'(bus.mismatch), 32'h0);

`ifdef HT_SEQ_TRIGGER_EN
    // Threshold: armed only after the TH-th qualifying edge
    for (int i = 0; i < int'(TH) - 1; i++) step(0, 1, 1, 4'b0101, 0);
    check("arm_before", 32'(bus.armed), 32'h0);
    step(0, 1, 1, 4'b0101, 0);
    check("arm_at", 32'(bus.armed), 32'h1);
    step(0, 0, 0, 4'b0101, 1);
    for (int i = 0; i < int'(CW) + 3; i++) step(0, 0, 0, 4'b0101, 0);
    check("arm_mis", 32'(bus.mismatch), 32'h5);
    check("arm_err", 32'(bus.err_cnt),  32'h1);
`endif

    // Start held high through a run: only one run, then a second toggles lv back
    for (int i = 0; i < int'(CW) + 4; i++) step(0, 0, 0, '0, 1);
    check("held_done", 32'(bus.done), 32'h1);
    step(0, 0, 0, '0, 0);
    check("held_idle", 32'(bus.busy), 32'h0);

    // Reset during WAIT
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 0);
    step(0, 0, 0, '0, 0);
    step(1, 0, 0, '0, 0);
    check("rstmid_busy", 32'(bus.busy),    32'h0);
    check("rstmid_err",  32'(bus.err_cnt), 32'h0);
    step(0, 0, 0, '0, 0);
    check("rstmid_done", 32'(bus.done), 32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), 1'($urandom), 1'($urandom),
           CH'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
